// File: rtl/timer_tick_pkg.sv
// Slave register map, CONTROL bit positions and FSM states for timer_tick_master.
// The snapshot states exist only when TIMER_TICK_SNAPSHOT_EN is defined.
package timer_tick_pkg;

   localparam logic [2:0] ADDR_STATUS  = 3'd0;
   localparam logic [2:0] ADDR_CONTROL = 3'd1;
   localparam logic [2:0] ADDR_PERIODL = 3'd2;
   localparam logic [2:0] ADDR_PERIODH = 3'd3;
   localparam logic [2:0] ADDR_SNAPL   = 3'd4;
   localparam logic [2:0] ADDR_SNAPH   = 3'd5;

   localparam int unsigned CTRL_ITO   = 0;
   localparam int unsigned CTRL_CONT  = 1;
   localparam int unsigned CTRL_START = 2;
   localparam int unsigned CTRL_STOP  = 3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_PL,
      ST_WR_PH,
      ST_WR_CTRL,
      ST_RUN,
      ST_CLR_STAT,
      ST_WR_STOP
`ifdef TIMER_TICK_SNAPSHOT_EN
      ,
      ST_SNAP_WR,
      ST_SNAP_RL,
      ST_SNAP_RH,
      ST_SNAP_DONE
`endif
   } state_e;

   function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                             input logic cont, input logic ito);
      logic [15:0] w;
      w             = '0;
      w[CTRL_STOP]  = stop;
      w[CTRL_START] = start;
      w[CTRL_CONT]  = cont;
      w[CTRL_ITO]   = ito;
      return w;
   endfunction

endpackage

// File: rtl/timer_tick_master.sv
// Avalon-MM master that programs an interval-timer slave, services its irq and
// optionally reads counter snapshots (enabled by define TIMER_TICK_SNAPSHOT_EN).
module timer_tick_master
   import timer_tick_pkg::*;
#(
   parameter int unsigned TICK_W     = 16,
   parameter bit          CONTINUOUS = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [31:0]       cfg_period,
   input  logic              snap_req,
   output logic [2:0]        avm_address,
   output logic              avm_chipselect,
   output logic              avm_write_n,
   output logic [15:0]       avm_writedata,
   input  logic [15:0]       avm_readdata,
   input  logic              irq,
   output logic              busy,
   output logic              running,
   output logic              tick,
   output logic [TICK_W-1:0] tick_count,
   output logic              snap_valid,
   output logic [31:0]       snap_value
);

   localparam logic [15:0] CTRL_RUN_WORD  = ctrl_word(1'b0, 1'b1, CONTINUOUS, 1'b1);
   localparam logic [15:0] CTRL_STOP_WORD = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);

   state_e              state_q, state_d;
   logic [31:0]         period_q;
   logic [TICK_W-1:0]   count_q;

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (start) state_d = ST_WR_PL;
         ST_WR_PL:    state_d = ST_WR_PH;
         ST_WR_PH:    state_d = ST_WR_CTRL;
         ST_WR_CTRL:  state_d = ST_RUN;
         ST_RUN: begin
            if (stop)          state_d = ST_WR_STOP;
            else if (irq)      state_d = ST_CLR_STAT;
`ifdef TIMER_TICK_SNAPSHOT_EN
            else if (snap_req) state_d = ST_SNAP_WR;
`endif
         end
         ST_CLR_STAT: state_d = ST_RUN;
         ST_WR_STOP:  state_d = ST_IDLE;
`ifdef TIMER_TICK_SNAPSHOT_EN
         ST_SNAP_WR:   state_d = ST_SNAP_RL;
         ST_SNAP_RL:   state_d = ST_SNAP_RH;
         ST_SNAP_RH:   state_d = ST_SNAP_DONE;
         ST_SNAP_DONE: state_d = ST_RUN;
`endif
         default:     state_d = ST_IDLE;
      endcase
   end

   // Bus outputs decode straight from state so a reset drops chipselect in the same cycle.
   always_comb begin
      // NOTE: every output gets a default before the case, so no path can infer a latch.
      avm_chipselect = 1'b0;
      avm_write_n    = 1'b1;
      avm_address    = ADDR_STATUS;
      avm_writedata  = '0;
      tick           = 1'b0;
      case (state_q)
         ST_WR_PL: begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            avm_address    = ADDR_PERIODL;
            avm_writedata  = period_q[15:0];
         end
         ST_WR_PH: begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            avm_address    = ADDR_PERIODH;
            avm_writedata  = period_q[31:16];
         end
         ST_WR_CTRL: begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            avm_address    = ADDR_CONTROL;
            avm_writedata  = CTRL_RUN_WORD;
         end
         ST_CLR_STAT: begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            avm_address    = ADDR_STATUS;
            tick           = 1'b1;
         end
         ST_WR_STOP: begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            avm_address    = ADDR_CONTROL;
            avm_writedata  = CTRL_STOP_WORD;
         end
`ifdef TIMER_TICK_SNAPSHOT_EN
         ST_SNAP_WR: begin
            avm_chipselect = 1'b1;
            avm_write_n    = 1'b0;
            avm_address    = ADDR_SNAPL;
         end
         ST_SNAP_RL: begin
            avm_chipselect = 1'b1;
            avm_address    = ADDR_SNAPL;
         end
         ST_SNAP_RH: begin
            avm_chipselect = 1'b1;
            avm_address    = ADDR_SNAPH;
         end
`endif
         default: ;
      endcase
   end

   assign busy    = (state_q != ST_IDLE) && (state_q != ST_RUN);
   assign running = !(state_q inside {ST_IDLE, ST_WR_PL, ST_WR_PH, ST_WR_CTRL});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_q <= '0;
         count_q  <= '0;
      end else if (state_q == ST_IDLE && start) begin
         period_q <= cfg_period;
         count_q  <= '0;
      end else if (state_q == ST_CLR_STAT) begin
         count_q  <= count_q + TICK_W'(1);
      end
   end

   assign tick_count = count_q;

`ifdef TIMER_TICK_SNAPSHOT_EN
   logic [31:0] snap_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                         snap_q         <= '0;
      else if (state_q == ST_SNAP_RH)    snap_q[15:0]   <= avm_readdata;
      else if (state_q == ST_SNAP_DONE)  snap_q[31:16]  <= avm_readdata;
   end

   // The high half bypasses the register so snap_value is whole while snap_valid is high.
   assign snap_valid = (state_q == ST_SNAP_DONE);
   assign snap_value = snap_valid ? {avm_readdata, snap_q[15:0]} : snap_q;
`else
   logic unused_snap;
   assign unused_snap = ^{snap_req, avm_readdata};
   assign snap_valid  = 1'b0;
   assign snap_value  = '0;
`endif

endmodule

// File: doc/timer_tick_master.md
TIMER_TICK_MASTER -- requirements
Module: timer_tick_master

Interface
REQ-001 Parameter: TICK_W, 16, width of tick_count.
REQ-002 Parameter: CONTINUOUS, 1, value written to control bit1 (CONT) at start.
REQ-003 Port: clk  in  1  single clock; all logic rising-edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: start  in  1  one-cycle pulse; program period and start the timer.
REQ-006 Port: stop  in  1  one-cycle pulse; stop the timer.
REQ-007 Port: cfg_period  in  32  period value, sampled on accepted start.
REQ-008 Port: snap_req  in  1  one-cycle pulse; request a counter snapshot.
REQ-009 Port: avm_address  out  3  word address to the timer slave.
REQ-010 Port: avm_chipselect  out  1  slave select.
REQ-011 Port: avm_write_n  out  1  active-low write strobe.
REQ-012 Port: avm_writedata  out  16  write data.
REQ-013 Port: avm_readdata  in  16  read data, valid exactly 1 cycle after address is presented.
REQ-014 Port: irq  in  1  timer interrupt, level, held until status is cleared.
REQ-015 Port: busy  out  1  high in every state except IDLE and RUN.
REQ-016 Port: running  out  1  high in RUN and the states reachable from it.
REQ-017 Port: tick  out  1  one-cycle pulse per serviced irq.
REQ-018 Port: tick_count  out  TICK_W  serviced-irq count.
REQ-019 Port: snap_valid  out  1  one-cycle pulse; snap_value valid.
REQ-020 Port: snap_value  out  32  captured counter snapshot.

Function
REQ-021 Slave map: 0 STATUS, 1 CONTROL, 2 PERIODL, 3 PERIODH, 4 SNAPL, 5 SNAPH; no waitrequest; each access is one cycle.
REQ-022 FSM states: IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_STAT, WR_STOP, SNAP_WR, SNAP_RL, SNAP_RH, SNAP_DONE.
REQ-023 IDLE + start: latch cfg_period, then go to WR_PL.
REQ-024 Start sequence, one cycle each:
- WR_PL writes period[15:0] @2.
- WR_PH writes period[31:16] @3.
- WR_CTRL writes {STOP=0, START=1, CONT=CONTINUOUS, ITO=1} @1, which is 0x0007 when CONTINUOUS=1.
- Then go to RUN.
REQ-025 RUN priority: stop > irq > snap_req.
- stop goes to WR_STOP.
- irq goes to CLR_STAT.
- snap_req goes to SNAP_WR.
REQ-026 CLR_STAT: write 0x0000 @0; pulse tick in the same cycle; increment tick_count; return to RUN (irq is low on the next cycle).
REQ-027 tick_count wraps modulo 2^TICK_W (all-ones to 0); it clears only on reset or on an accepted start.
REQ-028 WR_STOP: write 0x0008 @1 (STOP set, ITO cleared), then go to IDLE.
REQ-029 Snapshot read sequence:
- SNAP_WR writes 0x0000 @4.
- SNAP_RL presents read @4.
- SNAP_RH presents read @5 and captures avm_readdata as snap_value[15:0].
- SNAP_DONE captures avm_readdata as snap_value[31:16] and pulses snap_valid.
- Then go to RUN.
REQ-030 avm_chipselect=1 only in write/read states. avm_write_n=0 only in write states. Outside accesses: address=0, writedata=0.
REQ-031 Pulses arriving in non-accepting states are dropped:
- start outside IDLE.
- stop and snap_req outside RUN.
- stop or snap_req in IDLE.
REQ-032 A timeout coincident with the CLR_STAT write is lost, because the slave's status clear wins; tick does not pulse for it.
REQ-033 CONTINUOUS=0: after a one-shot expiry, irq is serviced once, then the FSM stays in RUN until stop.

Reset
REQ-034 Reset values:
- State IDLE.
- avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
- busy=0, running=0, tick=0, tick_count=0, snap_valid=0, snap_value=0.
REQ-035 Reset asserted mid-sequence aborts immediately with no further bus cycle; the slave is not reset by this block.

Configuration
REQ-036 Macro TIMER_TICK_SNAPSHOT_EN defined: snapshot path as REQ-029.
REQ-037 Macro TIMER_TICK_SNAPSHOT_EN undefined: SNAP_* states absent, snap_req ignored, snap_valid and snap_value tied to 0.

Structure
REQ-038 Package timer_tick_pkg holds:
- Slave address constants (REQ-021).
- CONTROL bit positions (ITO=0, CONT=1, START=2, STOP=3).
- The state enum.
REQ-039 Single module; no sub-module.

Verification
REQ-040 Start, cfg_period=0x0001_86A0: writes 0x86A0@2, 0x0001@3, 0x0007@1 on 3 consecutive cycles; then running=1, busy=0.
REQ-041 Three irq assertions in RUN: three CLR_STAT writes of 0x0000@0; tick pulses 3 times; tick_count=3.
REQ-042 tick_count=0xFFFF plus one irq: tick_count=0x0000, tick=1.
REQ-043 stop and irq in the same RUN cycle: 0x0008@1 written, no status write, tick_count unchanged, ends in IDLE.
REQ-044 snap_req with SNAPSHOT_EN; slave returns 0x1234@4 and 0x00AB@5: snap_valid pulses once, snap_value=0x00AB_1234, 4 cycles after snap_req.
REQ-045 Reset asserted during WR_PH: avm_chipselect=0 in the same cycle; state IDLE; a later start re-runs the full 3-write sequence.
